// File: rtl/quiz_game_pkg.sv
// rtl/quiz_game_pkg.sv - state encoding and display codes shared by quiz game blocks
package quiz_game_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_SHOW   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  // Digit codes above 9 select glyphs in the segment formatter
  localparam logic [3:0] VAL_DASH  = 4'd10;
  localparam logic [3:0] VAL_P     = 4'd11;
  localparam logic [3:0] VAL_T     = 4'd12;
  localparam logic [3:0] VAL_I     = 4'd13;
  localparam logic [3:0] VAL_E     = 4'd14;
  localparam logic [3:0] VAL_BLANK = 4'd15;

endpackage

// File: rtl/round_timer.sv
// rtl/round_timer.sv - loadable seconds down-counter for one player's round
module round_timer #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_en,
  output logic [TW-1:0] o_count,
  output logic          o_expire
);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign o_count  = r_count;
  assign o_expire = i_en && (r_count == TW'(1));

endmodule

// File: rtl/quiz_game_ctrl.sv
// rtl/quiz_game_ctrl.sv - quiz game sequencer: rounds, targets, scores, winner/tie
module quiz_game_ctrl
  import quiz_game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int DATA_W      = 8,
  parameter int SCORE_W     = 8,
  parameter int ROUND_SECS  = 30,
  localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int TW = $clog2(ROUND_SECS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick_1hz,
  input  logic                         start_p,
  input  logic                         submit_p,
  input  logic                         next_p,
  input  logic                         mode_p,
  input  logic                         restart_p,
  input  logic [DATA_W-1:0]            sw,
  input  logic [DATA_W-1:0]            rand_in,
  output logic [1:0]                   state,
  output logic                         two_comp,
  output logic [PW-1:0]                player,
  output logic [DATA_W-1:0]            target,
  output logic [TW-1:0]                time_left,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                         hit_p,
  output logic [PW-1:0]                winner,
  output logic                         tie
);

  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);

  logic [1:0]         r_state;
  logic               r_two_comp;
  logic [PW-1:0]      r_player;
  logic [DATA_W-1:0]  r_target;
  logic [SCORE_W-1:0] r_scores [NUM_PLAYERS];
  logic               r_hit;
  logic [PW-1:0]      r_winner;
  logic               r_tie;

  logic               w_abort;
  logic               w_hit;
  logic               w_expire;
  logic               w_tmr_en;
  logic               w_tmr_load;
  logic               w_advance;
  logic [DATA_W-1:0]  w_new_target;
  logic [SCORE_W-1:0] w_best;
  logic [PW-1:0]      w_win;
  logic               w_tie;

  assign w_abort      = restart_p && (r_state != ST_IDLE);
  assign w_hit        = (r_state == ST_PLAY) && !restart_p && submit_p && (sw == r_target);
  assign w_tmr_en     = (r_state == ST_PLAY) && !restart_p && tick_1hz;
  assign w_advance    = (r_state == ST_SHOW) && !restart_p && next_p && (r_player < LAST_PLAYER);
  assign w_tmr_load   = ((r_state == ST_IDLE) && start_p) || w_advance;
  // Never reload the value just matched, so a lucky repeat can't score twice
  assign w_new_target = (rand_in == r_target) ? (rand_in ^ DATA_W'(1)) : rand_in;

  round_timer #(.TW(TW)) u_round_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_abort),
    .i_load     (w_tmr_load),
    .i_load_val (TW'(ROUND_SECS)),
    .i_en       (w_tmr_en),
    .o_count    (time_left),
    .o_expire   (w_expire)
  );

  always_comb begin
    int n_max;
    w_best = r_scores[0];
    w_win  = '0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (r_scores[i] > w_best) begin
        w_best = r_scores[i];
        w_win  = PW'(i);
      end
    end
    n_max = 0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (r_scores[i] == w_best) n_max = n_max + 1;
    end
    w_tie = (n_max >= 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_two_comp <= 1'b0;
      r_player   <= '0;
      r_target   <= '0;
      r_hit      <= 1'b0;
      r_winner   <= '0;
      r_tie      <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) r_scores[i] <= '0;
    end else begin
      r_hit <= 1'b0;
      if (w_abort) begin
        r_state  <= ST_IDLE;
        r_player <= '0;
        r_target <= '0;
        r_winner <= '0;
        r_tie    <= 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) r_scores[i] <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (mode_p) r_two_comp <= ~r_two_comp;
            if (start_p) begin
              r_state  <= ST_PLAY;
              r_player <= '0;
              r_target <= rand_in;
              for (int i = 0; i < NUM_PLAYERS; i++) r_scores[i] <= '0;
            end
          end
          ST_PLAY: begin
            if (w_hit) begin
              r_hit    <= 1'b1;
              r_target <= w_new_target;
              if (r_scores[r_player] != '1)
                r_scores[r_player] <= r_scores[r_player] + SCORE_W'(1);
            end
            if (w_expire) r_state <= ST_SHOW;
          end
          ST_SHOW: begin
            if (next_p) begin
              if (r_player < LAST_PLAYER) begin
                r_state  <= ST_PLAY;
                r_player <= r_player + PW'(1);
                r_target <= rand_in;
              end else begin
                r_state  <= ST_RESULT;
                r_winner <= w_win;
                r_tie    <= w_tie;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    scores = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) scores[i*SCORE_W +: SCORE_W] = r_scores[i];
  end

  assign state    = r_state;
  assign two_comp = r_two_comp;
  assign player   = r_player;
  assign target   = r_target;
  assign hit_p    = r_hit;
  assign winner   = r_winner;
  assign tie      = r_tie;

endmodule
